// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding.
package restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/restoring_divider_ripple_subtractor.sv
// Ripple-carry subtractor: computes a - b as a + ~b + 1 over a chain of full adders.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   // One bit of sum and carry.
   always_comb begin
      s_o = a_i ^ b_i ^ c_i;
      c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
   end

endmodule

module ripple_subtractor #(
   parameter int N = 5
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] diff_o,
   output logic         borrow_o
);

   logic [N:0]   carry;
   logic [N-1:0] b_inv;

   assign b_inv    = ~b_i;
   // The +1 of the two's complement negation enters as the initial carry.
   assign carry[0] = 1'b1;
   // No carry out of the top bit means a < b.
   assign borrow_o = ~carry[N];

   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
         .a_i (a_i[i]),
         .b_i (b_inv[i]),
         .c_i (carry[i]),
         .s_o (diff_o[i]),
         .c_o (carry[i+1])
      );
   end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider with a start/done handshake.
// One shift plus one trial subtraction per clock; WIDTH iterations per division.

module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH:0]   a_q, a_d;            // partial remainder, one guard bit
   logic [WIDTH-1:0] q_q, q_d;            // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   a_shift;
   logic [WIDTH-1:0] q_shift;
   logic [WIDTH:0]   diff;
   logic             borrow;

   // {A,Q} shifted left by one: the dividend MSB moves into A.
   assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign q_shift = {q_q[WIDTH-2:0], 1'b0};

   ripple_subtractor #(.N(WIDTH + 1)) u_sub (
      .a_i      (a_shift),
      .b_i      ({1'b0, divisor_q}),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // Next-state, datapath and registered-output logic.
   always_comb begin
      // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latches).
      state_d     = state_q;
      count_d     = count_q;
      a_d         = a_q;
      q_d         = q_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               q_d       = dividend;
               divisor_d = divisor;
               a_d       = '0;
               count_d   = '0;
               dbz_d     = 1'b0;
               if (divisor == '0) begin
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            // A borrow is the same as a negative trial difference, since A stays below divisor.
            if (borrow) begin
               a_d = a_shift;
               q_d = {q_shift[WIDTH-1:1], 1'b0};
            end else begin
               a_d = diff;
               q_d = {q_shift[WIDTH-1:1], 1'b1};
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST_ITER) begin
               quotient_d  = q_d;
               remainder_d = a_d[WIDTH-1:0];
               state_d     = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CALC);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         count_q     <= '0;
         a_q         <= '0;
         q_q         <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         count_q     <= count_d;
         a_q         <= a_d;
         q_q         <= q_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with WIDTH = 4.
module tb_restoring_divider;

   localparam int W = 4;

   logic         clock;
   logic         resetn;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad   = 0;

   restoring_divider #(.WIDTH(W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at the negedge that is cycle lat0 after acceptance; returns the cycle where done is seen.
   task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
      lat      = lat0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat <= 20) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input int exp_q, input int exp_r, input int exp_dbz, input int exp_lat);
      int lat;
      int busy_cnt;
      @(negedge clock);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(negedge clock);
      start    = 1'b0;
      dividend = ~dd;
      divisor  = ~dv;
      wait_done(1, lat, busy_cnt);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_cnt, (exp_dbz != 0) ? 0 : W);
      check({tag, "_quotient"}, quotient, exp_q);
      check({tag, "_remainder"}, remainder, exp_r);
      check({tag, "_dbz"}, div_by_zero, exp_dbz);
      @(negedge clock);
      check({tag, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int extra;
      int gap;

      resetn   = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clock);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_dbz", div_by_zero, 0);
      resetn = 1'b1;

      // 1. Basic divide: 13 / 4 = 3 r1
      run_div("div_13_4", 4'd13, 4'd4, 3, 1, 0, 5);
      // Explicit corner vectors
      run_div("div_15_1", 4'd15, 4'd1, 15, 0, 0, 5);
      run_div("div_3_9", 4'd3, 4'd9, 0, 3, 0, 5);
      run_div("div_7_0", 4'd7, 4'd0, 15, 7, 1, 1);

      // 2. Full sweep of all operand pairs
      for (int dd = 0; dd < 16; dd++) begin
         for (int dv = 0; dv < 16; dv++) begin
            if (dv == 0)
               run_div("sweep_dbz", 4'(dd), 4'(dv), 15, dd, 1, 1);
            else
               run_div("sweep", 4'(dd), 4'(dv), dd / dv, dd % dv, 0, 5);
         end
      end

      // 3. Start during CALC is ignored
      @(negedge clock);
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd4;
      @(negedge clock);
      start = 1'b0;
      check("calc_busy", busy, 1);
      @(negedge clock);
      start    = 1'b1;
      dividend = 4'd7;
      divisor  = 4'd2;
      @(negedge clock);
      start = 1'b0;
      wait_done(3, lat, busy_cnt);
      check("calc_ignore_latency", lat, 5);
      check("calc_ignore_quotient", quotient, 3);
      check("calc_ignore_remainder", remainder, 1);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (done === 1'b1) extra++;
      end
      check("calc_ignore_extra_done", extra, 0);
      check("calc_ignore_hold_q", quotient, 3);

      // 4. Reset in the second CALC cycle
      @(negedge clock);
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd4;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_quotient", quotient, 0);
      check("midreset_remainder", remainder, 0);
      check("midreset_dbz", div_by_zero, 0);
      resetn = 1'b1;
      extra  = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (done === 1'b1) extra++;
      end
      check("midreset_no_done", extra, 0);
      run_div("after_reset_9_2", 4'd9, 4'd2, 4, 1, 0, 5);

      // 5. Back-to-back with start held high
      @(negedge clock);
      start    = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd3;
      @(negedge clock);
      wait_done(1, lat, busy_cnt);
      check("b2b_first_latency", lat, 5);
      check("b2b_first_quotient", quotient, 4);
      check("b2b_first_remainder", remainder, 2);
      dividend = 4'd8;
      divisor  = 4'd8;
      gap      = 0;
      do begin
         @(negedge clock);
         gap++;
         if (done !== 1'b1) check("b2b_hold_quotient", quotient, 4);
      end while (done !== 1'b1 && gap < 20);
      start = 1'b0;
      check("b2b_gap", gap, 5);
      check("b2b_second_quotient", quotient, 1);
      check("b2b_second_remainder", remainder, 0);
      check("b2b_second_dbz", div_by_zero, 0);
      @(negedge clock);
      check("b2b_done_drop", done, 0);
      check("b2b_result_hold", quotient, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
